sync_ram_dp_be: RTL and testbench

//  Parametrised simple dual-port synchronous RAM: one write port with per-byte enables and
//  one read port, on a single clock. Configurable read latency and read-during-write mode.

---
 rtl/sync_ram_dp_be.sv | 138 +++++++++++++
 tb/tb_sync_ram_dp_be.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_dp_be.sv
// Simple dual-port synchronous RAM: one byte-enabled write port, one read port,
// selectable read latency / read-during-write behaviour and a post-reset clear engine.
module sync_ram_dp_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             init_done,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   clr_addr_reg;
  logic                    init_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_reg  <= '0;
      init_done_reg <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (clr_addr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done = init_done_reg;

  logic clearing, wr_acc, rd_acc;
  assign clearing = (state_reg == ST_CLEAR);
  assign wr_acc   = init_done_reg & wr_en;
  assign rd_acc   = init_done_reg & rd_en;

  // The clear engine and the user write share the single physical write port.
  logic                  port_we;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic [NB-1:0]         port_be;
  logic [DATA_WIDTH-1:0] port_din;

  always_comb begin
    port_we   = clearing | wr_acc;
    port_addr = clearing ? clr_addr_reg : wr_addr;
    port_be   = clearing ? '1 : wr_be;
    port_din  = clearing ? '0 : wr_data;
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (port_we) begin
      for (int i = 0; i < NB; i++) begin
        if (port_be[i])
          mem[port_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write-first collisions forward the enabled write lanes over the stored word.
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;

  assign collide = wr_acc && (wr_addr == rd_addr) && (RDW_MODE == 0);
  assign rd_old  = mem[rd_addr];

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = (collide && wr_be[gi]) ?
        wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH] : rd_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_acc;
      if (rd_acc)
        s1_data_reg <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_reg;
    logic [DATA_WIDTH-1:0] s2_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_reg <= 1'b0;
        s2_data_reg  <= '0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg)
          s2_data_reg <= s1_data_reg;
      end
    end

    assign rd_data  = s2_data_reg;
    assign rd_valid = s2_valid_reg;
  end else begin : g_lat1
    assign rd_data  = s1_data_reg;
    assign rd_valid = s1_valid_reg;
  end

endmodule

// File: tb/tb_sync_ram_dp_be.sv
// Randomised + directed bench: two instances (latency 1 write-first, latency 2 read-first)
// share stimulus and are checked every cycle against an array/queue reference model.
module tb_sync_ram_dp_be;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;
  logic        init_done_a, rd_valid_a, init_done_b, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;

  always #5 clk = ~clk;

  sync_ram_dp_be #(.RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  sync_ram_dp_be #(.RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] mem_m [16];
  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] hold_a, hold_b;
  int          since, cyc;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
  endtask

  // Advance one clock edge: update the model from the current inputs, then check both DUTs.
  task automatic step();
    logic        ready;
    logic [31:0] old_w, mrg;
    rd_t         e;
    logic        va, vb;
    ready = (since >= 16);
    if (ready && rd_en) begin
      old_w = mem_m[rd_addr];
      mrg   = old_w;
      if (wr_en && wr_addr == rd_addr)
        for (int i = 0; i < 4; i++)
          if (wr_be[i]) mrg[i*8 +: 8] = wr_data[i*8 +: 8];
      e.due = cyc + 1; e.d = mrg;   qa.push_back(e);
      e.due = cyc + 2; e.d = old_w; qb.push_back(e);
    end
    if (ready && wr_en)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem_m[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
    cyc++;
    if (since < 16) begin
      since++;
      if (since == 16)
        for (int a = 0; a < 16; a++) mem_m[a] = '0;
    end
    @(posedge clk);
    #1;
    va = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front(); hold_a = e.d; va = 1'b1;
    end
    vb = 1'b0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front(); hold_b = e.d; vb = 1'b1;
    end
    chk("init_a", {31'd0, init_done_a}, {31'd0, since >= 16});
    chk("init_b", {31'd0, init_done_b}, {31'd0, since >= 16});
    chk("valid_a", {31'd0, rd_valid_a}, {31'd0, va});
    chk("valid_b", {31'd0, rd_valid_b}, {31'd0, vb});
    chk("data_a", rd_data_a, hold_a);
    chk("data_b", rd_data_b, hold_b);
  endtask

  // Asynchronous reset pulse away from clock edges; outputs must clear immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    hold_a = '0; hold_b = '0; since = 0;
    chk("rst_init_a", {31'd0, init_done_a}, 32'd0);
    chk("rst_init_b", {31'd0, init_done_b}, 32'd0);
    chk("rst_valid_a", {31'd0, rd_valid_a}, 32'd0);
    chk("rst_valid_b", {31'd0, rd_valid_b}, 32'd0);
    chk("rst_data_a", rd_data_a, 32'd0);
    chk("rst_data_b", rd_data_b, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic random_inputs(input bit allow_collide);
    wr_en   = 1'($urandom);
    rd_en   = 1'($urandom);
    wr_addr = 4'($urandom);
    wr_be   = 4'($urandom);
    wr_data = $urandom;
    rd_addr = (allow_collide && $urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    cyc = 0; since = 0; hold_a = '0; hold_b = '0;
    for (int a = 0; a < 16; a++) mem_m[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Clear phase with traffic that must be ignored, then read back every word.
    for (int i = 0; i < 16; i++) begin
      random_inputs(1'b1);
      step();
    end
    for (int a = 0; a < 16; a++) begin
      idle_inputs(); rd_en = 1'b1; rd_addr = 4'(a);
      step();
    end
    idle_inputs(); step(); step();

    // Byte-lane merge.
    wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'b1111; wr_data = 32'hA5A5A5A5; step();
    wr_be = 4'b0001; wr_data = 32'h11223344; step();
    idle_inputs(); rd_en = 1'b1; rd_addr = 4'd3; step();
    chk("t2_a", rd_data_a, 32'hA5A5A544);
    idle_inputs(); step();
    chk("t2_b", rd_data_b, 32'hA5A5A544);

    // Same-address read during write.
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b1111; wr_data = 32'hDEADBEEF; step();
    wr_be = 4'b0011; wr_data = 32'h12345678; rd_en = 1'b1; rd_addr = 4'd5; step();
    chk("t3_wf", rd_data_a, 32'hDEAD5678);
    idle_inputs(); step();
    chk("t3_rf", rd_data_b, 32'hDEADBEEF);
    rd_en = 1'b1; rd_addr = 4'd5; step();
    idle_inputs(); step();
    chk("t3_after_a", rd_data_a, 32'hDEAD5678);
    chk("t3_after_b", rd_data_b, 32'hDEAD5678);

    // Back-to-back reads, pipelined.
    for (int a = 0; a < 4; a++) begin
      idle_inputs(); rd_en = 1'b1; rd_addr = 4'(a);
      step();
    end
    idle_inputs(); step(); step();

    // Randomised traffic with frequent collisions.
    for (int i = 0; i < 400; i++) begin
      random_inputs(1'b1);
      step();
    end
    idle_inputs(); step(); step();

    // Reset part-way through the clear, traffic during the clear, then full readback.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      random_inputs(1'b1);
      step();
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      random_inputs(1'b0);
      step();
    end
    for (int a = 0; a < 16; a++) begin
      idle_inputs(); rd_en = 1'b1; rd_addr = 4'(a);
      step();
    end
    idle_inputs(); step(); step();

    // Reset with a latency-2 read still in flight.
    wr_en = 1'b1; wr_addr = 4'd9; wr_be = 4'b1111; wr_data = 32'hCAFEF00D; step();
    idle_inputs(); rd_en = 1'b1; rd_addr = 4'd9; step();
    chk("t6_a", rd_data_a, 32'hCAFEF00D);
    idle_inputs();
    do_reset();
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
